// File: rtl/riscv_cpu_pkg.sv
// Shared CPU package: datapath widths, memory opcode/funct3 constants,
// memory-stage FSM states and access-size helpers.
package riscv_cpu_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CSR_WIDTH  = 4;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_WAIT
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } mem_size_e;

    // Unsigned byte/half encodings only exist for loads; anything unknown is a word
    function automatic mem_size_e mem_size(input logic [2:0] funct3, input logic is_load);
        if (funct3 == F3_B || (is_load && funct3 == F3_BU)) begin
            return SIZE_B;
        end else if (funct3 == F3_H || (is_load && funct3 == F3_HU)) begin
            return SIZE_H;
        end else begin
            return SIZE_W;
        end
    endfunction

    function automatic logic [3:0] mem_be(input mem_size_e size, input logic [1:0] addr);
        case (size)
            SIZE_B:  return 4'b0001 << addr;
            SIZE_H:  return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// OBI-style data-memory port: req/gnt address phase, rvalid response phase.
interface mem_stage_if;

    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension for RV32I loads.
module load_align
    import riscv_cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data_ext
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to a full word
    always_comb begin
        shifted  = rdata >> {addr, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_ext = {24'h0, byte_sel};
            F3_H:    data_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_ext = {16'h0, half_sel};
            default: data_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on the data port, stalls upstream
// while a transaction is outstanding and registers the write-back result.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of issuing them with a forced-aligned address).
module mem_stage #(
    parameter int unsigned DATA_WIDTH = riscv_cpu_pkg::DATA_WIDTH,
    parameter int unsigned CSR_WIDTH  = riscv_cpu_pkg::CSR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [31:0]           instr_rdata_i,
    input  logic [31:0]           pc_ex_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic [CSR_WIDTH-1:0]  csr_i,
    output logic                  stall_o,
    mem_stage_if.master           dmem,
    output logic                  valid_o,
    output logic [31:0]           pc_mem_o,
    output logic [31:0]           instr_rdata_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [CSR_WIDTH-1:0]  csr_o,
    output logic                  misaligned_o
);

    import riscv_cpu_pkg::*;

    mem_state_e  state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store;
    mem_size_e   size;
    logic        misalign;
    logic        mem_op;
    logic        req, stall;
    logic [31:0] load_data;

    assign opcode   = instr_rdata_i[6:0];
    assign funct3   = instr_rdata_i[14:12];
    assign is_load  = (opcode == OPCODE_LOAD);
    assign is_store = (opcode == OPCODE_STORE);
    assign size     = mem_size(funct3, is_load);

`ifdef MEM_MISALIGN_TRAP_EN
    // Flag half/word accesses whose address is not naturally aligned
    always_comb begin
        misalign = 1'b0;
        if (valid_i && (is_load || is_store)) begin
            case (size)
                SIZE_H:  misalign = alu_result_i[0];
                SIZE_W:  misalign = |alu_result_i[1:0];
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = valid_i && (is_load || is_store) && !misalign;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, request and stall; the entry cycle requests directly from IDLE
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op) begin
                    req     = 1'b1;
                    stall   = 1'b1;
                    state_d = dmem.data_gnt ? MEM_WAIT : MEM_REQ;
                end
            end
            MEM_REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dmem.data_gnt) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stall = !dmem.data_rvalid;
                if (dmem.data_rvalid) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign dmem.data_req = req && rst_ni;
    assign stall_o       = stall && rst_ni;

    // Address-phase signals, zeroed whenever no request is presented
    always_comb begin
        dmem.data_addr  = '0;
        dmem.data_we    = 1'b0;
        dmem.data_be    = '0;
        dmem.data_wdata = '0;
        if (dmem.data_req) begin
            dmem.data_addr = {alu_result_i[31:2], 2'b00};
            dmem.data_we   = is_store;
            dmem.data_be   = mem_be(size, alu_result_i[1:0]);
            case (size)
                SIZE_B:  dmem.data_wdata = {4{data_b_i[7:0]}};
                SIZE_H:  dmem.data_wdata = {2{data_b_i[15:0]}};
                default: dmem.data_wdata = data_b_i;
            endcase
        end
    end

    load_align u_load_align (
        .rdata    (dmem.data_rdata),
        .addr     (alu_result_i[1:0]),
        .funct3   (funct3),
        .data_ext (load_data)
    );

    // Write-back register: bubble while stalled, otherwise capture the stage result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o       <= 1'b0;
            pc_mem_o      <= '0;
            instr_rdata_o <= '0;
            result_o      <= '0;
            csr_o         <= '0;
        end else if (stall_o) begin
            valid_o <= 1'b0;
        end else begin
            valid_o       <= valid_i;
            pc_mem_o      <= pc_ex_i;
            instr_rdata_o <= instr_rdata_i;
            result_o      <= (is_load && !misalign) ? load_data : alu_result_i;
            csr_o         <= csr_i;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalign flag travels with the registered result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misaligned_o <= 1'b0;
        end else if (!stall_o) begin
            misaligned_o <= misalign;
        end
    end
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expected values.
module tb_mem_stage;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] pc_ex_i;
    logic [31:0] alu_result_i;
    logic [31:0] data_b_i;
    logic [3:0]  csr_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] pc_mem_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] result_o;
    logic [3:0]  csr_o;
    logic        misaligned_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage_if dmem ();

    mem_stage #(
        .DATA_WIDTH (32),
        .CSR_WIDTH  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .instr_rdata_i (instr_rdata_i),
        .pc_ex_i       (pc_ex_i),
        .alu_result_i  (alu_result_i),
        .data_b_i      (data_b_i),
        .csr_i         (csr_i),
        .stall_o       (stall_o),
        .dmem          (dmem.master),
        .valid_o       (valid_o),
        .pc_mem_o      (pc_mem_o),
        .instr_rdata_o (instr_rdata_o),
        .result_o      (result_o),
        .csr_o         (csr_o),
        .misaligned_o  (misaligned_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'd1, op};
    endfunction

    initial begin
        rst_ni           = 1'b0;
        valid_i          = 1'b0;
        instr_rdata_i    = '0;
        pc_ex_i          = '0;
        alu_result_i     = '0;
        data_b_i         = '0;
        csr_i            = '0;
        dmem.data_gnt    = 1'b0;
        dmem.data_rvalid = 1'b0;
        dmem.data_rdata  = '0;

        // Reset state
        #12;
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_req", {31'h0, dmem.data_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_misal", {31'h0, misaligned_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // ADDI pass-through: one-cycle latency, no request
        valid_i       = 1'b1;
        instr_rdata_i = 32'h0420_0093;
        pc_ex_i       = 32'h0000_0100;
        alu_result_i  = 32'h0000_0042;
        csr_i         = 4'h5;
        #1;
        chk("addi_req", {31'h0, dmem.data_req}, 32'h0);
        chk("addi_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("addi_valid", {31'h0, valid_o}, 32'h1);
        chk("addi_result", result_o, 32'h0000_0042);
        chk("addi_pc", pc_mem_o, 32'h0000_0100);
        chk("addi_csr", {28'h0, csr_o}, 32'h5);
        valid_i = 1'b0;
        tick();
        chk("idle_valid", {31'h0, valid_o}, 32'h0);

        // LB at 0x1003, grant in request cycle, rvalid next cycle
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b000, 7'b0000011);
        pc_ex_i       = 32'h0000_0104;
        alu_result_i  = 32'h0000_1003;
        dmem.data_gnt = 1'b1;
        #1;
        chk("lb_req", {31'h0, dmem.data_req}, 32'h1);
        chk("lb_addr", dmem.data_addr, 32'h0000_1000);
        chk("lb_be", {28'h0, dmem.data_be}, 32'h8);
        chk("lb_we", {31'h0, dmem.data_we}, 32'h0);
        chk("lb_stall0", {31'h0, stall_o}, 32'h1);
        tick();
        dmem.data_gnt    = 1'b0;
        dmem.data_rvalid = 1'b1;
        dmem.data_rdata  = 32'h80FF_FF00;
        #1;
        chk("lb_bubble", {31'h0, valid_o}, 32'h0);
        chk("lb_req_w", {31'h0, dmem.data_req}, 32'h0);
        chk("lb_stall1", {31'h0, stall_o}, 32'h0);
        tick();
        dmem.data_rvalid = 1'b0;
        valid_i          = 1'b0;
        chk("lb_valid", {31'h0, valid_o}, 32'h1);
        chk("lb_result", result_o, 32'hFFFF_FF80);
        tick();

        // LHU at 0x2002, grant after three waiting cycles
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b101, 7'b0000011);
        alu_result_i  = 32'h0000_2002;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lhu_req_hold", {31'h0, dmem.data_req}, 32'h1);
            chk("lhu_addr_hold", dmem.data_addr, 32'h0000_2000);
            chk("lhu_be", {28'h0, dmem.data_be}, 32'hC);
            tick();
            chk("lhu_bubble", {31'h0, valid_o}, 32'h0);
        end
        dmem.data_gnt = 1'b1;
        #1;
        chk("lhu_req_gnt", {31'h0, dmem.data_req}, 32'h1);
        tick();
        dmem.data_gnt    = 1'b0;
        dmem.data_rvalid = 1'b1;
        dmem.data_rdata  = 32'hBEEF_1234;
        tick();
        dmem.data_rvalid = 1'b0;
        valid_i          = 1'b0;
        chk("lhu_valid", {31'h0, valid_o}, 32'h1);
        chk("lhu_result", result_o, 32'h0000_BEEF);
        tick();

        // SB at 0x3001, one idle cycle before rvalid
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b000, 7'b0100011);
        alu_result_i  = 32'h0000_3001;
        data_b_i      = 32'h0000_00A5;
        dmem.data_gnt = 1'b1;
        #1;
        chk("sb_we", {31'h0, dmem.data_we}, 32'h1);
        chk("sb_be", {28'h0, dmem.data_be}, 32'h2);
        chk("sb_wdata", dmem.data_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dmem.data_addr, 32'h0000_3000);
        tick();
        dmem.data_gnt = 1'b0;
        #1;
        chk("sb_wait_stall", {31'h0, stall_o}, 32'h1);
        tick();
        chk("sb_bubble", {31'h0, valid_o}, 32'h0);
        dmem.data_rvalid = 1'b1;
        dmem.data_rdata  = 32'hFFFF_FFFF;
        tick();
        dmem.data_rvalid = 1'b0;
        valid_i          = 1'b0;
        chk("sb_valid", {31'h0, valid_o}, 32'h1);
        chk("sb_result", result_o, 32'h0000_3001);
        tick();

        // SH at 0x6002: upper half lanes, halfword replicated
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b001, 7'b0100011);
        alu_result_i  = 32'h0000_6002;
        data_b_i      = 32'h1234_ABCD;
        dmem.data_gnt = 1'b1;
        #1;
        chk("sh_be", {28'h0, dmem.data_be}, 32'hC);
        chk("sh_wdata", dmem.data_wdata, 32'hABCD_ABCD);
        tick();
        dmem.data_gnt    = 1'b0;
        dmem.data_rvalid = 1'b1;
        tick();
        dmem.data_rvalid = 1'b0;
        valid_i          = 1'b0;
        chk("sh_valid", {31'h0, valid_o}, 32'h1);
        tick();

        // Reset asserted while waiting for a load response
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b010, 7'b0000011);
        alu_result_i  = 32'h0000_5000;
        dmem.data_gnt = 1'b1;
        tick();
        dmem.data_gnt = 1'b0;
        #1;
        chk("rstw_stall_pre", {31'h0, stall_o}, 32'h1);
        rst_ni        = 1'b0;
        valid_i       = 1'b0;
        instr_rdata_i = '0;
        alu_result_i  = '0;
        #1;
        chk("rstw_valid", {31'h0, valid_o}, 32'h0);
        chk("rstw_result", result_o, 32'h0);
        chk("rstw_pc", pc_mem_o, 32'h0);
        chk("rstw_stall", {31'h0, stall_o}, 32'h0);
        chk("rstw_req", {31'h0, dmem.data_req}, 32'h0);
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        dmem.data_rvalid = 1'b1;
        dmem.data_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("rstw_late_stall", {31'h0, stall_o}, 32'h0);
        tick();
        dmem.data_rvalid = 1'b0;
        chk("rstw_late_valid", {31'h0, valid_o}, 32'h0);
        chk("rstw_late_result", result_o, 32'h0);
        // FSM is back in IDLE: a pass-through completes in one cycle
        valid_i       = 1'b1;
        instr_rdata_i = 32'h0070_0093;
        alu_result_i  = 32'h0000_0007;
        #1;
        chk("rstw_idle_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("rstw_idle_valid", {31'h0, valid_o}, 32'h1);
        chk("rstw_idle_result", result_o, 32'h0000_0007);
        valid_i = 1'b0;
        tick();

        // LW at 0x4002
        valid_i       = 1'b1;
        instr_rdata_i = mk_instr(3'b010, 7'b0000011);
        alu_result_i  = 32'h0000_4002;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("mis_req", {31'h0, dmem.data_req}, 32'h0);
        chk("mis_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("mis_flag", {31'h0, misaligned_o}, 32'h1);
        chk("mis_result", result_o, 32'h0000_4002);
        chk("mis_valid", {31'h0, valid_o}, 32'h1);
`else
        dmem.data_gnt = 1'b1;
        #1;
        chk("mis_req", {31'h0, dmem.data_req}, 32'h1);
        chk("mis_addr", dmem.data_addr, 32'h0000_4000);
        chk("mis_be", {28'h0, dmem.data_be}, 32'hF);
        tick();
        dmem.data_gnt    = 1'b0;
        dmem.data_rvalid = 1'b1;
        dmem.data_rdata  = 32'h1122_3344;
        tick();
        dmem.data_rvalid = 1'b0;
        chk("mis_result", result_o, 32'h1122_3344);
        chk("mis_flag", {31'h0, misaligned_o}, 32'h0);
`endif
        valid_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
